// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FWFT FIFO: the per-cycle occupancy operation
// derived from the accepted write/read strobes.
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
      return fifo_op_e'({rd_acc, wr_acc});
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: registered write, combinational read.
// Contents are intentionally not reset.
module sync_fifo_mem #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [LGFLEN-1:0] i_waddr,
   input  logic [BW-1:0]     i_wdata,
   input  logic [LGFLEN-1:0] i_raddr,
   output logic [BW-1:0]     o_rdata
);

   logic [BW-1:0] mem_q [0:(1<<LGFLEN)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/fill.
// Optional sticky error outputs are enabled with SYNC_FIFO_ERRFLAGS_EN.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int BW                = 8,
   parameter int LGFLEN            = 4,
   parameter int OPT_WRITE_ON_FULL = 0
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   input  logic              i_rd,
   output logic [BW-1:0]     o_data,
   output logic              o_empty
`ifdef SYNC_FIFO_ERRFLAGS_EN
   ,
   output logic              o_overflow,
   output logic              o_underflow
`endif
);

   localparam logic [LGFLEN:0] FULL_FILL = {1'b1, {LGFLEN{1'b0}}};
   localparam logic [LGFLEN:0] PTR_ONE   = {{LGFLEN{1'b0}}, 1'b1};

   logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
   logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
   logic [LGFLEN:0] fill_q, fill_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            wr_acc, rd_acc;
   fifo_op_e        op;

   // A full FIFO can still take a write when the same cycle frees a slot.
   assign wr_acc = i_wr && (!full_q || ((OPT_WRITE_ON_FULL != 0) && i_rd));
   assign rd_acc = i_rd && !empty_q;
   assign op     = fifo_op(wr_acc, rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case (op)
         OP_PUSH: fill_d = fill_q + PTR_ONE;
         OP_POP:  fill_d = fill_q - PTR_ONE;
         default: fill_d = fill_q;
      endcase
      full_d  = (fill_d == FULL_FILL);
      empty_d = (fill_d == '0);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   sync_fifo_mem #(
      .BW     (BW),
      .LGFLEN (LGFLEN)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (wr_acc),
      .i_waddr (wr_ptr_q[LGFLEN-1:0]),
      .i_wdata (i_data),
      .i_raddr (rd_ptr_q[LGFLEN-1:0]),
      .o_rdata (o_data)
   );

   assign o_full  = full_q;
   assign o_empty = empty_q;
   assign o_fill  = fill_q;

`ifdef SYNC_FIFO_ERRFLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q  || (i_wr && !wr_acc);
      underflow_d = underflow_q || (i_rd && empty_q);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_overflow  = overflow_q;
   assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: two instances (write-on-full off/on) driven in lockstep,
// compared against queue-based reference models plus a directed vector table.
module tb_sync_fifo;

   localparam int BW     = 8;
   localparam int LGFLEN = 2;
   localparam int DEPTH  = 1 << LGFLEN;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr, rd;
   logic [BW-1:0] data;

   logic          full0, empty0, full1, empty1;
   logic [LGFLEN:0] fill0, fill1;
   logic [BW-1:0] dout0, dout1;
`ifdef SYNC_FIFO_ERRFLAGS_EN
   logic          ovf0, unf0, ovf1, unf1;
`endif

   int total = 0;
   int bad   = 0;

   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   logic          m_ovf0, m_unf0, m_ovf1, m_unf1;

   always #5 clk = ~clk;

   sync_fifo #(.BW(BW), .LGFLEN(LGFLEN), .OPT_WRITE_ON_FULL(0)) u0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data),
      .o_full(full0), .o_fill(fill0), .i_rd(rd), .o_data(dout0), .o_empty(empty0)
`ifdef SYNC_FIFO_ERRFLAGS_EN
      , .o_overflow(ovf0), .o_underflow(unf0)
`endif
   );

   sync_fifo #(.BW(BW), .LGFLEN(LGFLEN), .OPT_WRITE_ON_FULL(1)) u1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data),
      .o_full(full1), .o_fill(fill1), .i_rd(rd), .o_data(dout1), .o_empty(empty1)
`ifdef SYNC_FIFO_ERRFLAGS_EN
      , .o_overflow(ovf1), .o_underflow(unf1)
`endif
   );

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endfunction

   // Reference behaviour: a bounded queue; write-on-full allowed only when popping.
   task automatic model_step(input logic w, input logic [BW-1:0] d, input logic r);
      bit r0, w0, r1, w1;
      r0 = r && (q0.size() > 0);
      w0 = w && (q0.size() < DEPTH);
      r1 = r && (q1.size() > 0);
      w1 = w && ((q1.size() < DEPTH) || r);
      if (w && !w0) m_ovf0 = 1'b1;
      if (w && !w1) m_ovf1 = 1'b1;
      if (r && q0.size() == 0) m_unf0 = 1'b1;
      if (r && q1.size() == 0) m_unf1 = 1'b1;
      if (r0) void'(q0.pop_front());
      if (w0) q0.push_back(d);
      if (r1) void'(q1.pop_front());
      if (w1) q1.push_back(d);
   endtask

   task automatic check_all(string tag);
      chk({tag, ".fill0"},  int'(fill0),  q0.size());
      chk({tag, ".full0"},  int'(full0),  int'(q0.size() == DEPTH));
      chk({tag, ".empty0"}, int'(empty0), int'(q0.size() == 0));
      if (q0.size() != 0) chk({tag, ".data0"}, int'(dout0), int'(q0[0]));
      chk({tag, ".fill1"},  int'(fill1),  q1.size());
      chk({tag, ".full1"},  int'(full1),  int'(q1.size() == DEPTH));
      chk({tag, ".empty1"}, int'(empty1), int'(q1.size() == 0));
      if (q1.size() != 0) chk({tag, ".data1"}, int'(dout1), int'(q1[0]));
`ifdef SYNC_FIFO_ERRFLAGS_EN
      chk({tag, ".ovf0"}, int'(ovf0), int'(m_ovf0));
      chk({tag, ".unf0"}, int'(unf0), int'(m_unf0));
      chk({tag, ".ovf1"}, int'(ovf1), int'(m_ovf1));
      chk({tag, ".unf1"}, int'(unf1), int'(m_unf1));
`endif
   endtask

   task automatic cyc(input logic w, input logic [BW-1:0] d, input logic r, input string tag);
      @(negedge clk);
      wr = w; data = d; rd = r;
      @(posedge clk);
      model_step(w, d, r);
      #1;
      check_all(tag);
   endtask

   // Asserts reset between clock edges and checks the flags respond at once.
   task automatic do_reset(input string tag);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk({tag, ".fill0"},  int'(fill0),  0);
      chk({tag, ".empty0"}, int'(empty0), 1);
      chk({tag, ".full0"},  int'(full0),  0);
      chk({tag, ".fill1"},  int'(fill1),  0);
      chk({tag, ".empty1"}, int'(empty1), 1);
      q0.delete(); q1.delete();
      m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ovf1 = 1'b0; m_unf1 = 1'b0;
`ifdef SYNC_FIFO_ERRFLAGS_EN
      chk({tag, ".ovf0"}, int'(ovf0), 0);
      chk({tag, ".unf0"}, int'(unf0), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          w;
      logic [BW-1:0] d;
      logic          r;
      int            fill;
      logic          full;
      logic          empty;
      logic [BW-1:0] head;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h11};
      vt[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h11};
      vt[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 8'h11};
      vt[3] = '{1'b1, 8'h44, 1'b0, 4, 1'b1, 1'b0, 8'h11};
      vt[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0, 8'h11};
      vt[5] = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 8'h22};
      vt[6] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'h33};
      vt[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h44};
      vt[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00};

      rst_n = 1'b0; wr = 1'b0; rd = 1'b0; data = '0;
      m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ovf1 = 1'b0; m_unf1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.empty", int'(empty0), 1);
      chk("rst.full",  int'(full0),  0);
      chk("rst.fill",  int'(fill0),  0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, "idle");

      for (int i = 0; i < 9; i++) begin
         cyc(vt[i].w, vt[i].d, vt[i].r, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.fill", i),  int'(fill0),  vt[i].fill);
         chk($sformatf("vec%0d.full", i),  int'(full0),  int'(vt[i].full));
         chk($sformatf("vec%0d.empty", i), int'(empty0), int'(vt[i].empty));
         if (!vt[i].empty) chk($sformatf("vec%0d.head", i), int'(dout0), int'(vt[i].head));
      end

      cyc(1'b1, 8'hA1, 1'b0, "mid");
      cyc(1'b1, 8'hA2, 1'b0, "mid");
      cyc(1'b1, 8'hA3, 1'b0, "mid");
      do_reset("midrst");

      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'(i), 1'b0, "wrap.push");
         chk("wrap.head", int'(dout0), i);
         chk("wrap.le2", int'(fill0 <= 2), 1);
         cyc(1'b0, 8'h00, 1'b1, "wrap.pop");
         chk("wrap.le2b", int'(fill0 <= 2), 1);
      end

      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, "fillup");
      cyc(1'b1, 8'h66, 1'b1, "wof");
      chk("wof.fill0", int'(fill0), 3);
      chk("wof.fill1", int'(fill1), 4);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, "wof.drain");
      chk("wof.empty0", int'(empty0), 1);
      chk("wof.last1", int'(dout1), 8'h66);
      cyc(1'b0, 8'h00, 1'b1, "wof.drain");
      chk("wof.empty1", int'(empty1), 1);

      do_reset("rst2");
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
      end

`ifdef SYNC_FIFO_ERRFLAGS_EN
      do_reset("rst3");
      cyc(1'b0, 8'h00, 1'b1, "unf");
      chk("unf.set", int'(unf0), 1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'($urandom_range(0, 1)), "unf.hold");
      chk("unf.sticky", int'(unf0), 1);
      chk("ovf.set", int'(ovf0), int'(m_ovf0));
      do_reset("rst4");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
